// File: rtl/edge_event_scheduler.sv
// Edge-event scheduler: synchronizes raw level inputs, samples them on a divided tick,
// latches rising edges as pending events and offers them one at a time round-robin.
module edge_event_scheduler #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DIV = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         sig_in,
    output logic                   evt_valid,
    output logic [$clog2(NCH)-1:0] evt_id,
    input  logic                   evt_ready,
    output logic [NCH-1:0]         pending,
    output logic [NCH-1:0]         overrun
);

    localparam int unsigned IW = $clog2(NCH);
    localparam int unsigned CW = $clog2(DIV);

    typedef enum logic {
        StIdle,
        StOffer
    } state_e;

    state_e         state_q, state_d;
    logic [NCH-1:0] sync1_q, sync2_q;
    logic [NCH-1:0] prev_q, prev_d;
    logic [NCH-1:0] pending_q, pending_d;
    logic [NCH-1:0] overrun_q, overrun_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  id_q, id_d;
    logic [IW-1:0]  last_q, last_d;

    logic           tick;
    logic           hs;
    logic [NCH-1:0] edge_v;
    logic [NCH-1:0] hs_vec;
    logic [IW-1:0]  sel;
    logic [IW-1:0]  idx;
    logic           found;

    // Tick divider and edge detection; prev only advances on a tick.
    always_comb begin
        tick   = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        edge_v = tick ? (sync2_q & ~prev_q) : '0;
        prev_d = tick ? sync2_q : prev_q;
    end

    // A handshake clears its channel's flags; a coincident edge re-arms pending only.
    always_comb begin
        hs     = (state_q == StOffer) && evt_ready;
        hs_vec = '0;
        if (hs) begin
            hs_vec[id_q] = 1'b1;
        end
        pending_d = edge_v | (pending_q & ~hs_vec);
        overrun_d = (overrun_q | (edge_v & pending_q)) & ~hs_vec;
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        sel   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = last_q + IW'(k);
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_d    = last_q;
        evt_valid = 1'b0;
        case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    id_d    = sel;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    last_d  = id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            last_q    <= IW'(NCH - 1);
        end else begin
            state_q   <= state_d;
            sync1_q   <= sig_in;
            sync2_q   <= sync1_q;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            last_q    <= last_d;
        end
    end

    assign evt_id  = id_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Self-checking bench for edge_event_scheduler: scenario tasks plus a handshake
// scoreboard that pops the expected channel on every accepted event.
module tb_edge_event_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned DIV = 4;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] sig_in;
    logic           evt_valid;
    logic [1:0]     evt_id;
    logic           evt_ready;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int tb_cnt = 0;
    int sb[$];
    int hs_cyc[$];

    edge_event_scheduler #(
        .NCH(NCH),
        .DIV(DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sig_in   (sig_in),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_ready(evt_ready),
        .pending  (pending),
        .overrun  (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference tick phase: tick is the cycle where tb_cnt == DIV-1.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == DIV - 1) ? 0 : tb_cnt + 1;
    end

    // Scoreboard: every handshake must match the next expected channel.
    always @(negedge clk) begin
        if (reset && evt_valid && evt_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got evt_id=%0d, required no event", evt_id);
            end else begin
                int exp_id;
                exp_id = sb.pop_front();
                if (evt_id !== 2'(exp_id)) begin
                    errors++;
                    $display("FAIL sb_order: got evt_id=%0d, required %0d", evt_id, exp_id);
                end
            end
            hs_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset     = 1'b0;
        sig_in    = '0;
        evt_ready = 1'b0;
        sb.delete();
        hs_cyc.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        sig_in    = '0;
        evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b, required 0", evt_valid);
        end
        checks++;
        if (evt_id !== 2'd0) begin
            errors++; $display("FAIL reset_id: got %0d, required 0", evt_id);
        end
        checks++;
        if (pending !== 4'b0000) begin
            errors++; $display("FAIL reset_pending: got %b, required 0000", pending);
        end
        checks++;
        if (overrun !== 4'b0000) begin
            errors++; $display("FAIL reset_overrun: got %b, required 0000", overrun);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        int n;
        int extra;
        do_reset();
        evt_ready = 1'b1;
        sb.push_back(2);
        sig_in = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pending[2] !== 1'b1 && n < 20);
        checks++;
        if (n >= 20) begin
            errors++; $display("FAIL single_pending: got pending=%b, required bit 2 set", pending);
        end
        checks++;
        if (tb_cnt != 0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got phase=%0d valid=%b, required phase=0 valid=0",
                     tb_cnt, evt_valid);
        end
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            errors++;
            $display("FAIL single_offer: got valid=%b id=%0d, required valid=1 id=2",
                     evt_valid, evt_id);
        end
        @(negedge clk);
        checks++;
        if (pending !== 4'b0000 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_clear: got pending=%b valid=%b, required 0000 0",
                     pending, evt_valid);
        end
        extra = 0;
        repeat (3 * DIV) begin
            @(negedge clk);
            if (evt_valid === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL single_held: got %0d extra offers, %0d left, required 0 0",
                     extra, sb.size());
        end
    endtask

    task automatic test_all_four();
        int n;
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < NCH; i++) sb.push_back(i);
        sig_in = 4'b1111;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (hs_cyc.size() != 4) begin
            errors++; $display("FAIL four_count: got %0d handshakes, required 4", hs_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (hs_cyc[i] - hs_cyc[i-1] != 2) begin
                    errors++;
                    $display("FAIL four_spacing: got gap %0d, required 2",
                             hs_cyc[i] - hs_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        sb.push_back(1);
        sig_in = 4'b0010;
        repeat (2 * DIV) @(negedge clk);
        sig_in = 4'b0000;
        repeat (2 * DIV) @(negedge clk);
        sig_in = 4'b0010;
        repeat (2 * DIV + 2) @(negedge clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            errors++;
            $display("FAIL ovr_offer: got valid=%b id=%0d, required 1 1", evt_valid, evt_id);
        end
        checks++;
        if (pending !== 4'b0010 || overrun !== 4'b0010) begin
            errors++;
            $display("FAIL ovr_flags: got pending=%b overrun=%b, required 0010 0010",
                     pending, overrun);
        end
        @(posedge clk); #1;
        evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pending !== 4'b0000 || overrun !== 4'b0000) begin
            errors++;
            $display("FAIL ovr_clear: got pending=%b overrun=%b, required 0000 0000",
                     pending, overrun);
        end
        repeat (2 * DIV) @(negedge clk);
        sig_in = 4'b0000;
    endtask

    task automatic test_hold();
        int n;
        bit stable;
        do_reset();
        sb.push_back(0);
        sb.push_back(3);
        sig_in = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (evt_valid !== 1'b1 && n < 20);
        sig_in = 4'b1001;
        stable = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (evt_valid !== 1'b1 || evt_id !== 2'd0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++; $display("FAIL hold_stable: got id=%0d valid=%b, required 0 1", evt_id, evt_valid);
        end
        checks++;
        if (pending !== 4'b1001) begin
            errors++; $display("FAIL hold_pending: got %b, required 1001", pending);
        end
        @(posedge clk); #1;
        evt_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL hold_drain: got %0d left, required 0", sb.size());
        end
    endtask

    task automatic test_own_hs();
        int n;
        do_reset();
        sb.push_back(0);
        sig_in = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (evt_valid !== 1'b1 && n < 20);
        @(posedge clk); #1;
        sig_in = 4'b0000;
        repeat (2 * DIV) @(posedge clk);
        #1;
        sig_in = 4'b0001;
        repeat (2 * DIV) @(posedge clk);
        @(negedge clk);
        checks++;
        if (overrun[0] !== 1'b1 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL own_pre: got overrun=%b id=%0d, required overrun[0]=1 id=0",
                     overrun, evt_id);
        end
        @(posedge clk); #1;
        sig_in = 4'b0000;
        repeat (2 * DIV) @(posedge clk);
        // Raise so the synchronized edge lands in the tick cycle of the handshake.
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (tb_cnt != DIV - 3 && n < 2 * DIV);
        sig_in = 4'b0001;
        sb.push_back(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (pending[0] !== 1'b1 || overrun[0] !== 1'b0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL own_hs: got pending=%b overrun=%b valid=%b, required p0=1 o0=0 v=0",
                     pending, overrun, evt_valid);
        end
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL own_reoffer: got valid=%b id=%0d, required 1 0", evt_valid, evt_id);
        end
        @(posedge clk); #1;
        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
        sig_in = 4'b0000;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL own_drain: got %0d left, required 0", sb.size());
        end
    endtask

    task automatic test_reset_offer();
        int n;
        do_reset();
        sig_in = 4'b1011;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (evt_valid !== 1'b1 && n < 20);
        checks++;
        if (pending !== 4'b1011 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_pre: got pending=%b id=%0d, required 1011 0", pending, evt_id);
        end
        @(posedge clk); #3;
        reset  = 1'b0;
        sig_in = 4'b1010;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0000 || overrun !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async: got valid=%b pending=%b overrun=%b, required 0 0000 0000",
                     evt_valid, pending, overrun);
        end
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(1);
        sb.push_back(3);
        @(posedge clk); #1;
        evt_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL rst_drain: got %0d left, required 0", sb.size());
        end
        repeat (2 * DIV) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        sig_in    = '0;
        evt_ready = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_overrun();
        test_hold();
        test_own_hs();
        test_reset_offer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
